wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port behind the WB stage. The in-order pipeline write
//  ({regWrite,WB_Wd,rw} from WB) always has priority. Results from the multi-cycle MUL/DIV unit
//  (MDU) queue in a small FIFO and drain into free write slots. Decode queries a pending-write

---
 rtl/wb_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline WB write has priority, MDU results queue and
// drain into free slots. Define WBARB_BYPASS_EN to let an MDU result skip an empty queue.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_rw,
    input  logic [31:0]                pipe_wd,
    input  logic                       mdu_valid,
    input  logic [4:0]                 mdu_rw,
    input  logic [31:0]                mdu_wd,
    output logic                       mdu_ready,
    input  logic [4:0]                 q_rs,
    input  logic [4:0]                 q_rt,
    output logic                       q_hit,
    output logic                       pipe_hold,
    output logic [$clog2(DEPTH):0]     pend_cnt,
    output logic                       rf_we,
    output logic [4:0]                 rf_rw,
    output logic [31:0]                rf_wd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FullCnt   = CW'(DEPTH);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_t;

    state_t state_q, state_d;

    logic [4:0]    rw_q [DEPTH];
    logic [31:0]   wd_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;

    logic slot_busy, fifo_empty, accept, bypass, push, pop;

    assign slot_busy  = pipe_we && (pipe_rw != 5'd0);
    assign fifo_empty = (cnt_q == '0);
    assign mdu_ready  = (cnt_q != FullCnt);
    assign accept     = mdu_valid && mdu_ready;
    // Queue draining is suppressed while in reset; only the pipe path stays live.
    assign pop        = !rst && !slot_busy && !fifo_empty;

`ifdef WBARB_BYPASS_EN
    assign bypass = !rst && !slot_busy && fifo_empty && mdu_valid && (mdu_rw != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    assign push      = accept && (mdu_rw != 5'd0) && !bypass;
    assign pend_cnt  = cnt_q;
    assign pipe_hold = (state_q == StHold);

    always_comb begin
        rf_we = 1'b0;
        rf_rw = 5'd0;
        rf_wd = 32'd0;
        if (slot_busy) begin
            rf_we = 1'b1;
            rf_rw = pipe_rw;
            rf_wd = pipe_wd;
        end else if (pop) begin
            rf_we = 1'b1;
            rf_rw = rw_q[rd_ptr_q];
            rf_wd = wd_q[rd_ptr_q];
        end else if (bypass) begin
            rf_we = 1'b1;
            rf_rw = mdu_rw;
            rf_wd = mdu_wd;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (rw_q[i] != 5'd0) && ((rw_q[i] == q_rs) || (rw_q[i] == q_rt))) begin
                q_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                starve_d = '0;
                if (push) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_d == '0) begin
                    state_d  = StIdle;
                    starve_d = '0;
                end else if (pop) begin
                    starve_d = '0;
                end else if (starve_q == StarveMax) begin
                    state_d = StHold;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end
            StHold: begin
                if (cnt_d == '0) begin
                    state_d  = StIdle;
                    starve_d = '0;
                end else if (pop) begin
                    state_d  = StWait;
                    starve_d = '0;
                end
            end
            default: begin
                state_d  = StIdle;
                starve_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage needs no reset; valid_q and the count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            rw_q[wr_ptr_q] <= mdu_rw;
            wd_q[wr_ptr_q] <= mdu_wd;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with DEPTH=4, STARVE_LIMIT=8.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rw;
    logic [31:0] pipe_wd;
    logic        mdu_valid;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic [4:0]  q_rs, q_rt;
    logic        q_hit;
    logic        pipe_hold;
    logic [2:0]  pend_cnt;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_we   (pipe_we),
        .pipe_rw   (pipe_rw),
        .pipe_wd   (pipe_wd),
        .mdu_valid (mdu_valid),
        .mdu_rw    (mdu_rw),
        .mdu_wd    (mdu_wd),
        .mdu_ready (mdu_ready),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .q_hit     (q_hit),
        .pipe_hold (pipe_hold),
        .pend_cnt  (pend_cnt),
        .rf_we     (rf_we),
        .rf_rw     (rf_rw),
        .rf_wd     (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rw, input logic [31:0] wd);
        pipe_we = we;
        pipe_rw = rw;
        pipe_wd = wd;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rw, input logic [31:0] wd);
        mdu_valid = v;
        mdu_rw    = rw;
        mdu_wd    = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        q_rs = 5'd0;
        q_rt = 5'd0;
        #1;
        step();
        step();

        // Reset state
        check("rst_rf_we", rf_we, 0);
        check("rst_ready", mdu_ready, 1);
        check("rst_cnt", pend_cnt, 0);
        check("rst_hold", pipe_hold, 0);
        pipe(1'b1, 5'd3, 32'h0000_0033);
        #1;
        check("rst_pipe_we", rf_we, 1);
        check("rst_pipe_rw", rf_rw, 3);
        rst = 1'b0;
        pipe(1'b0, 5'd0, 32'd0);
        step();

        // Zero-latency pipe write
        pipe(1'b1, 5'd5, 32'h0000_1234);
        #1;
        check("pipe_we", rf_we, 1);
        check("pipe_rw", rf_rw, 5);
        check("pipe_wd", rf_wd, 32'h0000_1234);
        step();

        // Queued MDU result drains in first free slot
        pipe(1'b1, 5'd1, 32'h0000_0011);
        mdu(1'b1, 5'd8, 32'h0000_00AA);
        q_rs = 5'd8;
        #1;
        check("q_hit_same_cycle", q_hit, 0);
        check("busy_rw", rf_rw, 1);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        check("q_hit_c1", q_hit, 1);
        check("cnt_c1", pend_cnt, 1);
        check("busy_rw_c1", rf_rw, 1);
        step();
        q_rs = 5'd0;
        q_rt = 5'd8;
        #1;
        check("q_hit_rt", q_hit, 1);
        q_rt = 5'd7;
        #1;
        check("q_hit_miss", q_hit, 0);
        q_rs = 5'd8;
        step();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("drain_we", rf_we, 1);
        check("drain_rw", rf_rw, 8);
        check("drain_wd", rf_wd, 32'h0000_00AA);
        step();
        check("drain_cnt", pend_cnt, 0);
        check("drain_hit", q_hit, 0);
        check("idle_we", rf_we, 0);

        // Fill to DEPTH, reject a fifth, then drain
        pipe(1'b1, 5'd2, 32'h0000_0022);
        for (int i = 0; i < 4; i++) begin
            mdu(1'b1, 5'(10 + i), 32'(100 + i));
            #1;
            check("fill_ready", mdu_ready, 1);
            step();
        end
        mdu(1'b1, 5'd14, 32'd104);
        #1;
        check("full_cnt", pend_cnt, 4);
        check("full_ready", mdu_ready, 0);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        q_rs = 5'd14;
        #1;
        check("fifth_cnt", pend_cnt, 4);
        check("fifth_hit", q_hit, 0);
        check("fill_hold", pipe_hold, 0);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("pop_rw", rf_rw, 10);
        check("pop_wd", rf_wd, 100);
        check("pop_ready_same", mdu_ready, 0);
        step();
        check("pop_ready_next", mdu_ready, 1);
        check("pop_cnt", pend_cnt, 3);
        // A pipe write to reg 0 leaves the slot free
        pipe(1'b1, 5'd0, 32'hDEAD_BEEF);
        #1;
        check("r0_slot_rw", rf_rw, 11);
        check("r0_slot_wd", rf_wd, 101);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("pop3_rw", rf_rw, 12);
        step();
        check("pop4_rw", rf_rw, 13);
        step();
        check("empty_cnt", pend_cnt, 0);

        // Starvation: hold after 8 waiting cycles
        pipe(1'b1, 5'd2, 32'h0000_0022);
        mdu(1'b1, 5'd20, 32'h0000_0055);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("starve_no_hold", pipe_hold, 0);
            step();
        end
        check("starve_hold", pipe_hold, 1);
        step();
        check("starve_hold_stays", pipe_hold, 1);
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        check("hold_drain_rw", rf_rw, 20);
        check("hold_drain_wd", rf_wd, 32'h0000_0055);
        step();
        check("hold_release", pipe_hold, 0);
        check("hold_cnt", pend_cnt, 0);

        // Reg-0 MDU result is discarded
        mdu(1'b1, 5'd0, 32'd77);
        #1;
        check("mdu_r0_we", rf_we, 0);
        step();
        check("mdu_r0_cnt", pend_cnt, 0);

        // Free slot, empty queue, MDU result to reg 9
        mdu(1'b1, 5'd9, 32'd99);
        #1;
`ifdef WBARB_BYPASS_EN
        check("bypass_we", rf_we, 1);
        check("bypass_rw", rf_rw, 9);
        check("bypass_wd", rf_wd, 99);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        check("bypass_cnt", pend_cnt, 0);
`else
        check("nobyp_we", rf_we, 0);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        #1;
        check("nobyp_cnt", pend_cnt, 1);
        check("nobyp_rw", rf_rw, 9);
        check("nobyp_wd", rf_wd, 99);
        step();
        check("nobyp_cnt_after", pend_cnt, 0);
`endif

        // Simultaneous push and pop keeps the count
        pipe(1'b1, 5'd2, 32'h0000_0022);
        mdu(1'b1, 5'd21, 32'd210);
        step();
        pipe(1'b0, 5'd0, 32'd0);
        mdu(1'b1, 5'd22, 32'd220);
        #1;
        check("pp_rw", rf_rw, 21);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        q_rs = 5'd22;
        #1;
        check("pp_cnt", pend_cnt, 1);
        check("pp_hit", q_hit, 1);
        check("pp_next_rw", rf_rw, 22);
        step();
        check("pp_empty", pend_cnt, 0);

        // Reset mid-operation discards the queue
        pipe(1'b1, 5'd2, 32'h0000_0022);
        mdu(1'b1, 5'd23, 32'd230);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_cnt", pend_cnt, 0);
        q_rs = 5'd23;
        #1;
        check("midrst_hit", q_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
